// File: rtl/hls_mac_pkg.sv
// Shared constants and arithmetic helpers for the hls_mac_pipe multiply-accumulate unit.
// Helpers operate on a 64-bit signed working width, so the accumulator width must stay at or below 62 bits.
package hls_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Arithmetic right shift with round-half-up; a shift of zero passes the value through.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        if (sh <= 0) begin
            return v;
        end
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] v, input int pw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (pw - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int pw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (pw - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/hls_mac_pipe_mul_pipe.sv
// Enable-gated operand extension register followed by MUL_STAGES product registers.
// The valid bit and the mode/first/last side-band travel alongside each beat.
module hls_mac_mul_pipe
    import hls_mac_pkg::*;
#(
    parameter int A_WIDTH    = 13,
    parameter int A_SIGNED   = 0,
    parameter int B_WIDTH    = 14,
    parameter int B_SIGNED   = 1,
    parameter int MUL_STAGES = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_en,
    input  logic                             i_valid,
    input  logic [A_WIDTH-1:0]               i_a,
    input  logic [B_WIDTH-1:0]               i_b,
    input  logic                             i_mode,
    input  logic                             i_first,
    input  logic                             i_last,
    output logic                             o_valid,
    output logic                             o_mode,
    output logic                             o_first,
    output logic                             o_last,
    output logic signed [A_WIDTH+B_WIDTH:0]  o_prod
);

    localparam int PW = A_WIDTH + B_WIDTH + 1;

    logic                 w_a_msb;
    logic                 w_b_msb;
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;

    logic signed [PW-1:0] r_a;
    logic signed [PW-1:0] r_b;
    logic signed [PW-1:0] r_prod [1:MUL_STAGES];
    logic [MUL_STAGES:0]  r_v;
    logic [MUL_STAGES:0]  r_mode;
    logic [MUL_STAGES:0]  r_first;
    logic [MUL_STAGES:0]  r_last;

    // PW bits hold the exact product of any signed/unsigned operand mix.
    assign w_a_msb = (A_SIGNED != 0) ? i_a[A_WIDTH-1] : 1'b0;
    assign w_b_msb = (B_SIGNED != 0) ? i_b[B_WIDTH-1] : 1'b0;
    assign w_a_ext = {{(PW - A_WIDTH){w_a_msb}}, i_a};
    assign w_b_ext = {{(PW - B_WIDTH){w_b_msb}}, i_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_v     <= '0;
            r_mode  <= '0;
            r_first <= '0;
            r_last  <= '0;
            for (int s = 1; s <= MUL_STAGES; s++) begin
                r_prod[s] <= '0;
            end
        end else if (i_en) begin
            r_a       <= w_a_ext;
            r_b       <= w_b_ext;
            r_v       <= {r_v[MUL_STAGES-1:0], i_valid};
            r_mode    <= {r_mode[MUL_STAGES-1:0], i_mode};
            r_first   <= {r_first[MUL_STAGES-1:0], i_first};
            r_last    <= {r_last[MUL_STAGES-1:0], i_last};
            r_prod[1] <= r_a * r_b;
            for (int s = 2; s <= MUL_STAGES; s++) begin
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    assign o_valid = r_v[MUL_STAGES];
    assign o_mode  = r_mode[MUL_STAGES];
    assign o_first = r_first[MUL_STAGES];
    assign o_last  = r_last[MUL_STAGES];
    assign o_prod  = r_prod[MUL_STAGES];

endmodule

// File: rtl/hls_mac_pipe.sv
// Pipelined multiply-accumulate for the dense-layer datapath: multiplier pipe, accumulator
// with a multiply-only bypass, round/saturate output register and valid/ready handshake.
module hls_mac_pipe
    import hls_mac_pkg::*;
#(
    parameter int A_WIDTH    = 13,
    parameter int A_SIGNED   = 0,
    parameter int B_WIDTH    = 14,
    parameter int B_SIGNED   = 1,
    parameter int MUL_STAGES = 3,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 0,
    parameter int P_WIDTH    = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    input  logic               in_mode,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] out_p,
    output logic               out_sat
);

    localparam int PW = A_WIDTH + B_WIDTH + 1;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high.
    // The whole pipe advances only when the output slot is empty or being drained, so
    // in_ready never depends on in_valid and out_valid never drops without out_ready.
    logic                        w_adv;
    logic                        w_pv;
    logic                        w_pmode;
    logic                        w_pfirst;
    logic                        w_plast;
    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_acc;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_emit_val;
    logic signed [63:0]          w_rounded;
    logic                        w_emit;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_out_valid;
    logic [P_WIDTH-1:0]          r_out_p;
    logic                        r_out_sat;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    hls_mac_mul_pipe #(
        .A_WIDTH    (A_WIDTH),
        .A_SIGNED   (A_SIGNED),
        .B_WIDTH    (B_WIDTH),
        .B_SIGNED   (B_SIGNED),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_adv),
        .i_valid (in_valid),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_mode  (in_mode),
        .i_first (in_first),
        .i_last  (in_last),
        .o_valid (w_pv),
        .o_mode  (w_pmode),
        .o_first (w_pfirst),
        .o_last  (w_plast),
        .o_prod  (w_prod)
    );

    // Multiply-only beats bypass the accumulator so an in-progress sum is untouched.
    assign w_prod_acc = ACC_WIDTH'(w_prod);
    assign w_sum      = w_pfirst ? w_prod_acc : (r_acc + w_prod_acc);
    assign w_emit     = w_pv && ((w_pmode == MODE_MUL) || w_plast);
    assign w_emit_val = (w_pmode == MODE_MUL) ? w_prod_acc : w_sum;
    assign w_rounded  = round_shift(64'(w_emit_val), SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_adv && w_pv && (w_pmode == MODE_ACC)) begin
            r_acc <= w_sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_p   <= P_WIDTH'(saturate(w_rounded, P_WIDTH));
                r_out_sat <= sat_hit(w_rounded, P_WIDTH);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_hls_mac_pipe.sv
// Bench for hls_mac_pipe: a default instance and a SHIFT=2 / 14-bit-output instance share
// one stimulus stream and are scored against a transaction-level MAC model.
module tb_hls_mac_pipe;

    localparam int AW  = 13;
    localparam int BW  = 14;
    localparam int P0  = 23;
    localparam int P1  = 14;
    localparam int SH1 = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          in_mode = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready0, out_valid0, out_sat0;
    logic [P0-1:0] out_p0;
    logic          in_ready1, out_valid1, out_sat1;
    logic [P1-1:0] out_p1;

    always #5 clk = ~clk;

    hls_mac_pipe dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0), .out_sat(out_sat0)
    );

    hls_mac_pipe #(.SHIFT(SH1), .P_WIDTH(P1)) dut1 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_p(out_p1), .out_sat(out_sat1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_acc = 0;
    logic [P0:0] exp_q0[$];
    logic [P1:0] exp_q1[$];
    longint      got_p0[$];
    logic        got_s0[$];
    longint      got_p1[$];

    function automatic void model_out(input longint v, input int sh, input int pw,
                                      output logic sat, output longint r);
        longint hi;
        longint lo;
        longint step;
        r = v;
        if (sh > 0) begin
            step = longint'(1) <<< sh;
            r = v + step / 2;
            // floor division by 2^sh
            if (r < 0 && (r % step) != 0) r = r / step - 1;
            else r = r / step;
        end
        hi  = (longint'(1) <<< (pw - 1)) - 1;
        lo  = -hi - 1;
        sat = (r > hi) || (r < lo);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
    endfunction

    function automatic void model_push(input longint v);
        logic   s;
        longint r;
        model_out(v, 0, P0, s, r);
        exp_q0.push_back({s, r[P0-1:0]});
        model_out(v, SH1, P1, s, r);
        exp_q1.push_back({s, r[P1-1:0]});
    endfunction

    function automatic void model_beat(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                       input logic m, input logic f, input logic l);
        longint prod;
        prod = longint'(a) * longint'($signed(b));
        if (!m) begin
            model_push(prod);
        end else begin
            if (f) m_acc = prod;
            else   m_acc = longint'(int'(m_acc + prod));
            if (l) model_push(m_acc);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          stalled0 = 1'b0;
    logic [P0-1:0] hold_p0 = '0;
    logic          hold_s0 = 1'b0;
    int            stall_cnt = 0;

    always @(negedge clk) begin
        logic [P0:0] e0;
        logic [P1:0] e1;
        if (!rst_n) begin
            stalled0 = 1'b0;
        end else begin
            check("in_ready0", in_ready0, !out_valid0 || out_ready);
            check("in_ready1", in_ready1, !out_valid1 || out_ready);
            if (stalled0) begin
                check("hold_valid", out_valid0, 1);
                check("hold_p", out_p0, hold_p0);
                check("hold_sat", out_sat0, hold_s0);
            end
            stalled0 = out_valid0 && !out_ready;
            hold_p0  = out_p0;
            hold_s0  = out_sat0;
            if (stalled0) stall_cnt++;
            if (out_valid0 && out_ready) begin
                if (exp_q0.size() == 0) begin
                    check("spurious0", out_valid0, 0);
                end else begin
                    e0 = exp_q0.pop_front();
                    check("p0", out_p0, e0[P0-1:0]);
                    check("sat0", out_sat0, e0[P0]);
                end
                got_p0.push_back(longint'($signed(out_p0)));
                got_s0.push_back(out_sat0);
            end
            if (out_valid1 && out_ready) begin
                if (exp_q1.size() == 0) begin
                    check("spurious1", out_valid1, 0);
                end else begin
                    e1 = exp_q1.pop_front();
                    check("p1", out_p1, e1[P1-1:0]);
                    check("sat1", out_sat1, e1[P1]);
                end
                got_p1.push_back(longint'($signed(out_p1)));
            end
            if (in_valid && in_ready0) model_beat(in_a, in_b, in_mode, in_first, in_last);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid0, 0);
        check("rst_p", out_p0, 0);
        check("rst_sat", out_sat0, 0);
        check("rst_in_ready", in_ready0, 1);
        m_acc = 0;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic m, input logic f, input logic l, input bit rand_bp);
        logic ok;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = m;
        in_first = f;
        in_last = l;
        do begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            n++;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain0", exp_q0.size(), 0);
        check("drain1", exp_q1.size(), 0);
    endtask

    task automatic clear_got();
        got_p0.delete();
        got_s0.delete();
        got_p1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;

        do_reset();

        // mode 0, latency
        clear_got();
        send(13'd100, -14'sd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid0 && n < 20);
        check("latency", n, 4);
        drain();
        check("t1_count", got_p0.size(), 1);
        check("t1_p0", got_p0[0], -300);
        check("t1_sat0", got_s0[0], 0);
        check("t1_p1", got_p1[0], -75);

        // saturation
        clear_got();
        send(13'd8191, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        check("sat_p0", got_p0[0], -4194304);
        check("sat_s0", got_s0[0], 1);
        check("sat_p1", got_p1[0], -8192);

        // accumulate
        clear_got();
        send(13'd2, 14'sd3, 1'b1, 1'b1, 1'b0, 1'b0);
        send(13'd4, -14'sd5, 1'b1, 1'b0, 1'b0, 1'b0);
        send(13'd1, 14'sd7, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        check("acc_count", got_p0.size(), 1);
        check("acc_p0", got_p0[0], -7);
        check("acc_p1", got_p1[0], -2);

        // backpressure
        clear_got();
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(AW'(i + 1), 14'sd10, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", got_p0.size(), 8);
        for (int i = 0; i < 8; i++) check("bp_order", got_p0[i], 10 * (i + 1));
        check("bp_stall_seen", stall_cnt > 0, 1);

        // rounding on the shifted instance
        clear_got();
        send(13'd2, 14'sd3, 1'b0, 1'b0, 1'b0, 1'b0);
        send(13'd2, -14'sd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        check("rnd_pos", got_p1[0], 2);
        check("rnd_neg", got_p1[1], -1);

        // reset mid-sum
        clear_got();
        send(13'd5, 14'sd5, 1'b1, 1'b1, 1'b0, 1'b0);
        send(13'd6, 14'sd6, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send(13'd1, 14'sd1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        check("rst_count", got_p0.size(), 1);
        check("rst_p0", got_p0[0], 1);

        // accumulate without first right after reset starts from zero
        do_reset();
        clear_got();
        send(13'd3, 14'sd4, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        check("nofirst_p0", got_p0[0], 12);
        check("nofirst_p1", got_p1[0], 3);

        // randomized traffic with random backpressure and bubbles
        for (int i = 0; i < 400; i++) begin
            ra = AW'($urandom);
            rb = BW'($urandom);
            send(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
